if_fetch: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline, directly upstream of the IF/ID pipeline register. It owns the fetch PC, runs a request/acknowledge handshake with instruction memory, and delivers (pc, instr, valid) to IF/ID. It absorbs variable memory latency and downstream stalls with a two-entry output buffer, and it handles branch/jump redirects without ever abandoning an in-flight memory request.

---
 rtl/if_pkg.sv | 23 ++
 rtl/fetch_skid_buf.sv | 87 ++++++++
 rtl/if_fetch.sv | 150 +++++++++++++++
 tb/tb_if_fetch.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction-fetch stage: fetch FSM states,
// the default reset PC, the nop encoding and the sequential PC increment.
// ---------------------------------------------------------------------------
package if_pkg;

    // IDLE  : post-reset bubble, no request
    // REQ   : request outstanding at pc_q
    // HOLD  : buffer full, fetch paused
    // DRAIN : redirect pending, waiting to retire the old request
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

endpackage : if_pkg

// File: rtl/fetch_skid_buf.sv
// ---------------------------------------------------------------------------
// fetch_skid_buf
// Two-entry output buffer for the fetch stage. Entry O drives the outputs,
// entry S backs it up so one fetched instruction can be parked while the
// downstream stage is stalled.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   push                  new instruction from memory this cycle
//   push_pc, push_instr   address / word of the pushed instruction
//   consume               downstream takes the O entry this cycle
//   clear                 drop both entries (redirect)
//   out_valid/pc/instr    contents of O; out_instr is NOP when O is empty
//   s_full                S currently holds an instruction
// ---------------------------------------------------------------------------
module fetch_skid_buf
    import if_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] push_pc,
    input  logic [31:0] push_instr,
    input  logic        consume,
    input  logic        clear,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        s_full
);

    logic        o_vld;
    logic [31:0] o_pc;
    logic [31:0] o_instr;
    logic        s_vld;
    logic [31:0] s_pc;
    logic [31:0] s_instr;
    logic        o_free;

    // O can accept new data when it is empty or being taken this cycle.
    assign o_free = ~o_vld | consume;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_vld   <= 1'b0;
            o_pc    <= 32'h0;
            o_instr <= NOP;
            s_vld   <= 1'b0;
            s_pc    <= 32'h0;
            s_instr <= NOP;
        end else if (clear) begin
            o_vld <= 1'b0;
            s_vld <= 1'b0;
        end else if (consume && s_vld) begin
            // S advances into O; an arriving word refills S behind it.
            o_pc    <= s_pc;
            o_instr <= s_instr;
            if (push) begin
                s_pc    <= push_pc;
                s_instr <= push_instr;
            end else begin
                s_vld <= 1'b0;
            end
        end else if (o_free) begin
            // S is empty here, so the arriving word goes straight to O.
            if (push) begin
                o_vld   <= 1'b1;
                o_pc    <= push_pc;
                o_instr <= push_instr;
            end else begin
                o_vld <= 1'b0;
            end
        end else if (push) begin
            // O is held by a stall; park the word in S. The fetch FSM never
            // pushes while S is occupied, so nothing valid is overwritten.
            s_vld   <= 1'b1;
            s_pc    <= push_pc;
            s_instr <= push_instr;
        end
    end

    assign out_valid = o_vld;
    assign out_pc    = o_pc;
    assign out_instr = o_vld ? o_instr : NOP;
    assign s_full    = s_vld;

endmodule : fetch_skid_buf

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
// Instruction-fetch stage. Owns the fetch PC, runs a req/ack handshake with
// instruction memory (at most one request outstanding, request held stable
// until acknowledged) and delivers (pc, instr, valid) to the IF/ID register
// through a two-entry skid buffer. Redirects never abandon an in-flight
// request: the old request is drained and its data discarded.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   stall_i          hazard stall, also holds IF/ID
//   redirect_i       one-cycle taken branch/jump pulse
//   redirect_pc_i    redirect target (bits [1:0] ignored)
//   imem_req_o       registered memory request
//   imem_addr_o      request address (= pc_q)
//   imem_ack_i       memory completes the current request
//   imem_rdata_i     instruction word, valid with imem_ack_i
//   valid_o          output holds a live instruction
//   pc_o, instr_o    delivered instruction; instr_o is nop when invalid
// ---------------------------------------------------------------------------
module if_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  redir_q, redir_d;
    logic         req_q, req_d;

    logic         ack;
    logic         consume;
    logic         push;
    logic         s_full;
    logic         o_free;
    logic         s_full_if_push;
    logic         s_full_if_idle;
    logic [31:0]  target;

    assign target  = redirect_pc_i & ~32'h3;
    // An ack is only meaningful while a request is actually outstanding.
    assign ack     = imem_ack_i & req_q;
    assign consume = valid_o & ~stall_i;
    assign o_free  = ~valid_o | consume;

    // Occupancy of S after this edge, for the cases with and without a
    // push. A push lands in S unless O is free and S empty.
    assign s_full_if_push = ~(o_free & ~s_full);
    assign s_full_if_idle = s_full & ~consume;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        redir_d = redir_q;
        push    = 1'b0;

        if (redirect_i) begin
            unique case (state_q)
                REQ: begin
                    if (ack) begin
                        pc_d = target;
                    end else begin
                        redir_d = target;
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    // Latest target wins, even if the drain completes now.
                    if (ack) begin
                        pc_d    = target;
                        state_d = REQ;
                    end else begin
                        redir_d = target;
                    end
                end
                default: begin
                    pc_d    = target;
                    state_d = REQ;
                end
            endcase
        end else begin
            unique case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (ack) begin
                        push    = 1'b1;
                        pc_d    = pc_q + PC_STEP;
                        state_d = s_full_if_push ? HOLD : REQ;
                    end
                end
                HOLD: state_d = s_full_if_idle ? HOLD : REQ;
                DRAIN: begin
                    if (ack) begin
                        pc_d    = redir_q;
                        state_d = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        req_d = (state_d == REQ) || (state_d == DRAIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            redir_q <= 32'h0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            redir_q <= redir_d;
            req_q   <= req_d;
        end
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = pc_q;

    fetch_skid_buf u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_pc    (pc_q),
        .push_instr (imem_rdata_i),
        .consume    (consume),
        .clear      (redirect_i),
        .out_valid  (valid_o),
        .out_pc     (pc_o),
        .out_instr  (instr_o),
        .s_full     (s_full)
    );

endmodule : if_fetch

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch
// Self-checking bench for if_fetch: a queue-based behavioural model of the
// fetch stage plus a simple wait-state memory, compared every cycle, with
// directed phases and a randomized phase.
// ---------------------------------------------------------------------------
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] instr_o;

    if_fetch #(.RESET_PC(32'h0000_3000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .valid_o       (valid_o),
        .pc_o          (pc_o),
        .instr_o       (instr_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: the buffer is a plain queue (front = delivered entry)
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    localparam int M_IDLE  = 0;
    localparam int M_REQ   = 1;
    localparam int M_HOLD  = 2;
    localparam int M_DRAIN = 3;

    ent_t        mq[$];
    int          mmode;
    logic [31:0] mpc;
    logic [31:0] mpend;

    // Bench control
    int          phase;
    int          wcnt;
    int          cur_nw;
    int          stall_left;
    bit          redir_arm;
    bit          seq_on;
    bit          have_last;
    logic [31:0] last_pc;
    logic [31:0] log_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    function automatic int wait_for(input logic [31:0] a);
        case (phase)
            2:       return 2;
            4:       return (a == 32'h0000_300C) ? 3 : 0;
            5:       return $urandom_range(0, 3);
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mmode = M_IDLE;
        mpc   = 32'h0000_3000;
        mpend = 32'h0;
    endtask

    task automatic model_step(input bit st, input bit rd, input logic [31:0] tgt,
                              input bit ack, input logic [31:0] rdata);
        bit          mack;
        logic [31:0] t;
        ent_t        e;
        mack = ack && (mmode == M_REQ || mmode == M_DRAIN);
        t    = tgt & ~32'h3;
        if (rd) begin
            mq.delete();
            case (mmode)
                M_REQ:   if (mack) mpc = t; else begin mpend = t; mmode = M_DRAIN; end
                M_DRAIN: if (mack) begin mpc = t; mmode = M_REQ; end else mpend = t;
                default: begin mpc = t; mmode = M_REQ; end
            endcase
        end else begin
            if (mq.size() > 0 && !st) void'(mq.pop_front());
            case (mmode)
                M_IDLE: mmode = M_REQ;
                M_REQ: begin
                    if (mack) begin
                        e.pc = mpc;
                        e.instr = rdata;
                        mq.push_back(e);
                        mpc = mpc + 32'd4;
                        mmode = (mq.size() == 2) ? M_HOLD : M_REQ;
                    end
                end
                M_HOLD:  mmode = (mq.size() == 2) ? M_HOLD : M_REQ;
                default: if (mack) begin mpc = mpend; mmode = M_REQ; end
            endcase
        end
    endtask

    task automatic cycle();
        bit          st, rd, ack, dv, req_s;
        logic [31:0] tgt, rdata, dpc;
        @(negedge clk);
        chk("valid_o", {31'b0, valid_o}, {31'b0, mq.size() > 0});
        chk("imem_req_o", {31'b0, imem_req_o}, {31'b0, (mmode == M_REQ || mmode == M_DRAIN)});
        chk("imem_addr_o", imem_addr_o, mpc);
        if (mq.size() > 0) begin
            chk("pc_o", pc_o, mq[0].pc);
            chk("instr_o", instr_o, mq[0].instr);
        end else begin
            chk("instr_o_nop", instr_o, 32'h0);
        end
        dv    = valid_o;
        dpc   = pc_o;
        req_s = imem_req_o;

        ack   = 1'b0;
        rdata = $urandom;
        if (imem_req_o) begin
            if (wcnt == 0) cur_nw = wait_for(imem_addr_o);
            if (wcnt >= cur_nw) begin
                ack   = 1'b1;
                rdata = mem_word(imem_addr_o);
            end
        end

        st = 1'b0; rd = 1'b0; tgt = 32'h0;
        case (phase)
            3: if (stall_left > 0) begin st = 1'b1; stall_left--; end
            4: if (redir_arm && imem_req_o && imem_addr_o == 32'h0000_300C && wcnt == 1) begin
                   rd = 1'b1; tgt = 32'h0000_4002; redir_arm = 1'b0;
               end
            5: begin
                st = ($urandom_range(0, 3) == 0);
                rd = ($urandom_range(0, 11) == 0);
                case ($urandom_range(0, 3))
                    0:       tgt = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                    1:       tgt = 32'h0000_3000 + $urandom_range(0, 63);
                    default: tgt = $urandom;
                endcase
            end
            6: if (redir_arm && ack && valid_o) begin
                   rd = 1'b1; st = 1'b1; tgt = 32'h0000_5001; redir_arm = 1'b0;
               end
            default: ;
        endcase

        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = tgt;
        imem_ack_i    = ack;
        imem_rdata_i  = rdata;

        @(posedge clk);
        if (rd) begin
            log_q.delete();
            have_last = 1'b0;
        end else if (dv && !st) begin
            log_q.push_back(dpc);
            if (seq_on && have_last) chk("pc_sequence", dpc, last_pc + 32'd4);
            last_pc   = dpc;
            have_last = 1'b1;
        end
        if (ack) wcnt = 0;
        else if (req_s) wcnt++;
        model_step(st, rd, tgt, ack, rdata);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid_o"}, {31'b0, valid_o}, 32'h0);
        chk({tag, "_pc_o"}, pc_o, 32'h0);
        chk({tag, "_instr_o"}, instr_o, 32'h0);
        chk({tag, "_imem_req_o"}, {31'b0, imem_req_o}, 32'h0);
        chk({tag, "_imem_addr_o"}, imem_addr_o, 32'h0000_3000);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        imem_ack_i    = 1'b0;
        imem_rdata_i  = 32'h0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        wcnt = 0;
        cur_nw = 0;
        log_q.delete();
        have_last = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("held_rst");
        rst = 1'b0;
        @(posedge clk);
        model_step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        int guard;
        stall_left = 0;
        redir_arm  = 1'b0;
        seq_on     = 1'b1;
        have_last  = 1'b0;
        last_pc    = 32'h0;
        wcnt       = 0;
        cur_nw     = 0;
        model_reset();

        // Zero-wait streaming after reset
        phase = 1;
        do_reset();
        repeat (12) cycle();
        chk("zw_first_pc",  (log_q.size() > 0) ? log_q[0] : 32'hDEAD_BEEF, 32'h0000_3000);
        chk("zw_second_pc", (log_q.size() > 1) ? log_q[1] : 32'hDEAD_BEEF, 32'h0000_3004);
        chk("zw_third_pc",  (log_q.size() > 2) ? log_q[2] : 32'hDEAD_BEEF, 32'h0000_3008);

        // Two wait cycles per request: one instruction per three cycles
        phase = 2;
        repeat (6) cycle();
        log_q.delete();
        repeat (30) cycle();
        chk("wait2_rate", log_q.size(), 32'd10);

        // Asynchronous reset while a request is waiting
        guard = 0;
        while (wcnt != 1 && guard < 10) begin
            cycle();
            guard++;
        end
        chk("midwait_found", wcnt, 32'd1);
        phase = 1;
        do_reset();
        repeat (4) cycle();
        chk("restart_pc", (log_q.size() > 0) ? log_q[0] : 32'hDEAD_BEEF, 32'h0000_3000);

        // Five-cycle stall with zero-wait memory
        phase = 3;
        repeat (3) cycle();
        stall_left = 5;
        repeat (12) cycle();
        chk("stall_len", stall_left, 32'd0);

        // Redirect while the request to 0x300C waits
        phase = 4;
        do_reset();
        redir_arm = 1'b1;
        repeat (20) cycle();
        chk("redir_fired", {31'b0, redir_arm}, 32'h0);
        chk("redir_first_pc", (log_q.size() > 0) ? log_q[0] : 32'hDEAD_BEEF, 32'h0000_4000);

        // Redirect together with stall in an ack cycle
        phase = 1;
        repeat (4) cycle();
        phase = 6;
        redir_arm = 1'b1;
        repeat (8) cycle();
        chk("redir_stall_fired", {31'b0, redir_arm}, 32'h0);
        chk("redir_stall_first_pc", (log_q.size() > 0) ? log_q[0] : 32'hDEAD_BEEF, 32'h0000_5000);

        // Randomized stalls, redirects and memory latency
        phase = 5;
        do_reset();
        repeat (3000) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_if_fetch
